instr_mem_stage: RTL and testbench
==================================

# instr_mem_stage

Memory pipeline stage between execute and writeback. Accepts one instruction per cycle from execute, performs word load/store accesses on the data-memory port with a req/ack handshake, and stalls upstream while an access is outstanding. Registers the writeback bundle (data candidates, select hotcode, destination, enable, full instruction) consumed by the writeback stage. Inserts bubbles while stalled.

## Interface
- ADDR_WIDTH, 16, data-memory word-address width
- TIMEOUT_CYCLES, 16, cycles in ACCESS before abort (1..255)

- clock  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- ex_mem_valid  in  1  execute bundle valid
- ex_mem_full_instruction  in  32  instruction word (VGA pass-through)
- ex_mem_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- ex_mem_address  in  32  word address (execute result)
- ex_mem_store_data  in  32  store data
- ex_mem_arithmetic_data  in  32  execute result
- ex_mem_move_data  in  32  move operand
- ex_mem_writeback_enable  in  2  register write enable
- ex_mem_writeback_register  in  3  destination encoding
- ex_mem_writeback_select  in  3  hotcode: 100 arithmetic, 010 memory, 001 move
- mem_stall  out  1  upstream must hold bundle
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_WIDTH  ex_mem_address[ADDR_WIDTH-1:0]; upper bits ignored
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  access complete
- mem_wb_full_instruction  out  32  to writeback
- memory_writeback_data  out  32  load result
- arithmetic_writeback_data  out  32
- move_writeback_data  out  32
- register_writeback_enable  out  2
- writeback_register_encoding  out  3
- writeback_data_select_hotcode  out  3
- mem_fault  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, ex_mem_valid=1, op none/11: bundle registered to writeback outputs at the edge; memory_writeback_data=0; stay IDLE.
- IDLE, ex_mem_valid=1, op load/store: latch addr/wdata/we and bundle; go ACCESS; writeback outputs get bubble at that edge.
- IDLE, ex_mem_valid=0: bubble at edge.
- Bubble = register_writeback_enable 0, writeback_data_select_hotcode 000, other writeback outputs 0.
- ACCESS: dmem_req=1; dmem_we/addr/wdata held stable; mem_stall=1; bubble each edge.
- ACCESS, dmem_ack=1: at edge, writeback outputs load latched bundle; memory_writeback_data = dmem_rdata for load, 0 for store; go IDLE; counter cleared.
- ACCESS, no ack for TIMEOUT_CYCLES cycles: at the TIMEOUT_CYCLES-th edge, abort, mem_fault<=1, bubble, go IDLE. Ack on that same edge wins (normal completion, no fault).
- mem_fault cleared only by reset.
- ex_mem inputs consumed only at edges with state IDLE; ignored in ACCESS.

## Timing
- mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata: decoded from registered state only; no combinational input-to-output paths.
- Non-memory op: 1-cycle latency, back-to-back throughput.
- Memory op: request visible cycle after acceptance; result at ack edge; zero-wait ack → 2 cycles accept-to-output, 1 bubble.
- mem_stall drops cycle after ack edge; next bundle accepted at the following edge.
- Reset (async, reset_n=0): state IDLE, dmem_req/we 0, dmem_addr/wdata 0, mem_stall 0, all writeback outputs 0, mem_fault 0, counter 0. Reset mid-ACCESS drops dmem_req immediately; transaction abandoned, no writeback.

## Configuration
- MEM_TIMEOUT_EN defined: timeout counter and abort path present as above.
- Not defined: ACCESS waits indefinitely for dmem_ack; no counter; mem_fault tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Reset, then ALU op (select 100, data 0x12345678, reg 3, enable 01): next edge outputs match; mem_stall never high.
- Load addr 0x0010, memory acks after 3 wait cycles with 0xDEADBEEF: dmem_addr 0x0010, mem_stall high 4 cycles, bubbles, then memory_writeback_data 0xDEADBEEF, select 010.
- Store 0xCAFEF00D to 0x0020, zero-wait ack: dmem_we=1, dmem_wdata 0xCAFEF00D for 1 cycle; enable passed as given; next ALU op accepted after stall drops.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load never acked: abort at 4th ACCESS edge, mem_fault=1 sticky, bubble, returns IDLE; ack on 4th edge instead → normal completion, fault 0.
- reset_n low mid-ACCESS: dmem_req 0 immediately, all outputs 0; after release, new load completes normally.

Source files
------------

// File: rtl/instr_mem_stage_if.sv
// Bundle interface for instr_mem_stage: execute-side inputs, data-memory port and writeback outputs.
// master = environment (execute stage, memory, writeback), slave = the memory stage itself.
interface instr_mem_stage_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  ex_mem_valid;
    logic [31:0]           ex_mem_full_instruction;
    logic [1:0]            ex_mem_mem_op;
    logic [31:0]           ex_mem_address;
    logic [31:0]           ex_mem_store_data;
    logic [31:0]           ex_mem_arithmetic_data;
    logic [31:0]           ex_mem_move_data;
    logic [1:0]            ex_mem_writeback_enable;
    logic [2:0]            ex_mem_writeback_register;
    logic [2:0]            ex_mem_writeback_select;

    logic                  mem_stall;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [31:0]           dmem_rdata;
    logic                  dmem_ack;

    logic [31:0]           mem_wb_full_instruction;
    logic [31:0]           memory_writeback_data;
    logic [31:0]           arithmetic_writeback_data;
    logic [31:0]           move_writeback_data;
    logic [1:0]            register_writeback_enable;
    logic [2:0]            writeback_register_encoding;
    logic [2:0]            writeback_data_select_hotcode;
    logic                  mem_fault;

    modport master (
        output ex_mem_valid, ex_mem_full_instruction, ex_mem_mem_op, ex_mem_address,
               ex_mem_store_data, ex_mem_arithmetic_data, ex_mem_move_data,
               ex_mem_writeback_enable, ex_mem_writeback_register, ex_mem_writeback_select,
               dmem_rdata, dmem_ack,
        input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               mem_wb_full_instruction, memory_writeback_data, arithmetic_writeback_data,
               move_writeback_data, register_writeback_enable, writeback_register_encoding,
               writeback_data_select_hotcode, mem_fault
    );

    modport slave (
        input  ex_mem_valid, ex_mem_full_instruction, ex_mem_mem_op, ex_mem_address,
               ex_mem_store_data, ex_mem_arithmetic_data, ex_mem_move_data,
               ex_mem_writeback_enable, ex_mem_writeback_register, ex_mem_writeback_select,
               dmem_rdata, dmem_ack,
        output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               mem_wb_full_instruction, memory_writeback_data, arithmetic_writeback_data,
               move_writeback_data, register_writeback_enable, writeback_register_encoding,
               writeback_data_select_hotcode, mem_fault
    );
endinterface

// File: rtl/instr_mem_stage.sv
// Memory pipeline stage: word load/store over a req/ack port, stalls upstream while an access is open.
// Define MEM_TIMEOUT_EN to add the ACCESS timeout counter and the sticky mem_fault abort path.
//
// state  | meaning
// IDLE   | accepting a bundle every edge; non-memory ops pass straight to writeback
// ACCESS | memory request outstanding; upstream stalled, bubbles to writeback
module instr_mem_stage #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    instr_mem_stage_if.slave   bus
);
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic [31:0] lat_instr_q, lat_instr_d;
    logic [31:0] lat_arith_q, lat_arith_d;
    logic [31:0] lat_move_q, lat_move_d;
    logic [1:0]  lat_en_q, lat_en_d;
    logic [2:0]  lat_reg_q, lat_reg_d;
    logic [2:0]  lat_sel_q, lat_sel_d;

    logic [31:0] wb_instr_q, wb_instr_d;
    logic [31:0] wb_mem_q, wb_mem_d;
    logic [31:0] wb_arith_q, wb_arith_d;
    logic [31:0] wb_move_q, wb_move_d;
    logic [1:0]  wb_en_q, wb_en_d;
    logic [2:0]  wb_reg_q, wb_reg_d;
    logic [2:0]  wb_sel_q, wb_sel_d;

    logic is_mem_op;
    logic timeout_hit;

    assign is_mem_op = (bus.ex_mem_mem_op == 2'b01) || (bus.ex_mem_mem_op == 2'b10);

    generate
        if (ADDR_WIDTH < 32) begin : g_addr_trunc
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.ex_mem_address[31:ADDR_WIDTH];
        end
    endgenerate

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;

    // Down-counter loaded on entry; reaching zero on an ACCESS edge is the final allowed cycle.
    assign timeout_hit = (state_q == S_ACCESS) && (cnt_q == 8'd0);

    always_comb begin
        cnt_d   = '0;
        fault_d = fault_q | (timeout_hit && !bus.dmem_ack);
        if (state_q == S_IDLE) begin
            if (bus.ex_mem_valid && is_mem_op) cnt_d = 8'(TIMEOUT_CYCLES - 1);
        end else if (!bus.dmem_ack && !timeout_hit) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign bus.mem_fault = fault_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.mem_fault = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_instr_d = lat_instr_q;
        lat_arith_d = lat_arith_q;
        lat_move_d  = lat_move_q;
        lat_en_d    = lat_en_q;
        lat_reg_d   = lat_reg_q;
        lat_sel_d   = lat_sel_q;
        wb_instr_d  = '0;
        wb_mem_d    = '0;
        wb_arith_d  = '0;
        wb_move_d   = '0;
        wb_en_d     = '0;
        wb_reg_d    = '0;
        wb_sel_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.ex_mem_valid) begin
                    if (is_mem_op) begin
                        state_d     = S_ACCESS;
                        we_d        = (bus.ex_mem_mem_op == 2'b10);
                        addr_d      = bus.ex_mem_address[ADDR_WIDTH-1:0];
                        wdata_d     = bus.ex_mem_store_data;
                        lat_instr_d = bus.ex_mem_full_instruction;
                        lat_arith_d = bus.ex_mem_arithmetic_data;
                        lat_move_d  = bus.ex_mem_move_data;
                        lat_en_d    = bus.ex_mem_writeback_enable;
                        lat_reg_d   = bus.ex_mem_writeback_register;
                        lat_sel_d   = bus.ex_mem_writeback_select;
                    end else begin
                        wb_instr_d = bus.ex_mem_full_instruction;
                        wb_arith_d = bus.ex_mem_arithmetic_data;
                        wb_move_d  = bus.ex_mem_move_data;
                        wb_en_d    = bus.ex_mem_writeback_enable;
                        wb_reg_d   = bus.ex_mem_writeback_register;
                        wb_sel_d   = bus.ex_mem_writeback_select;
                    end
                end
            end
            S_ACCESS: begin
                // A same-edge ack beats the timeout.
                if (bus.dmem_ack) begin
                    state_d    = S_IDLE;
                    wb_instr_d = lat_instr_q;
                    wb_mem_d   = we_q ? 32'h0 : bus.dmem_rdata;
                    wb_arith_d = lat_arith_q;
                    wb_move_d  = lat_move_q;
                    wb_en_d    = lat_en_q;
                    wb_reg_d   = lat_reg_q;
                    wb_sel_d   = lat_sel_q;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_instr_q <= '0;
            lat_arith_q <= '0;
            lat_move_q  <= '0;
            lat_en_q    <= '0;
            lat_reg_q   <= '0;
            lat_sel_q   <= '0;
            wb_instr_q  <= '0;
            wb_mem_q    <= '0;
            wb_arith_q  <= '0;
            wb_move_q   <= '0;
            wb_en_q     <= '0;
            wb_reg_q    <= '0;
            wb_sel_q    <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_instr_q <= lat_instr_d;
            lat_arith_q <= lat_arith_d;
            lat_move_q  <= lat_move_d;
            lat_en_q    <= lat_en_d;
            lat_reg_q   <= lat_reg_d;
            lat_sel_q   <= lat_sel_d;
            wb_instr_q  <= wb_instr_d;
            wb_mem_q    <= wb_mem_d;
            wb_arith_q  <= wb_arith_d;
            wb_move_q   <= wb_move_d;
            wb_en_q     <= wb_en_d;
            wb_reg_q    <= wb_reg_d;
            wb_sel_q    <= wb_sel_d;
        end
    end

    assign bus.mem_stall  = (state_q == S_ACCESS);
    assign bus.dmem_req   = (state_q == S_ACCESS);
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;

    assign bus.mem_wb_full_instruction       = wb_instr_q;
    assign bus.memory_writeback_data         = wb_mem_q;
    assign bus.arithmetic_writeback_data     = wb_arith_q;
    assign bus.move_writeback_data           = wb_move_q;
    assign bus.register_writeback_enable     = wb_en_q;
    assign bus.writeback_register_encoding   = wb_reg_q;
    assign bus.writeback_data_select_hotcode = wb_sel_q;
endmodule

// File: tb/tb_instr_mem_stage.sv
// Self-checking bench for instr_mem_stage: vector table, directed multi-cycle sequences, randomized transactions.
module tb_instr_mem_stage;
    localparam int AW = 16;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_stage_if #(.ADDR_WIDTH(AW)) bif ();

    instr_mem_stage #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bif.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] arith;
        logic [31:0] move;
        logic [1:0]  en;
        logic [2:0]  rg;
        logic [2:0]  sel;
    } in_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] mem;
        logic [31:0] arith;
        logic [31:0] move;
        logic [1:0]  en;
        logic [2:0]  rg;
        logic [2:0]  sel;
    } wb_t;

    typedef struct {
        in_t in;
        wb_t exp;
    } vec_t;

    localparam wb_t BUBBLE = '0;

    task automatic drive(input in_t v);
        bif.ex_mem_valid              = v.valid;
        bif.ex_mem_full_instruction   = v.instr;
        bif.ex_mem_mem_op             = v.op;
        bif.ex_mem_address            = v.addr;
        bif.ex_mem_store_data         = v.sdata;
        bif.ex_mem_arithmetic_data    = v.arith;
        bif.ex_mem_move_data          = v.move;
        bif.ex_mem_writeback_enable   = v.en;
        bif.ex_mem_writeback_register = v.rg;
        bif.ex_mem_writeback_select   = v.sel;
    endtask

    function automatic wb_t actual_wb();
        wb_t w;
        w.instr = bif.mem_wb_full_instruction;
        w.mem   = bif.memory_writeback_data;
        w.arith = bif.arithmetic_writeback_data;
        w.move  = bif.move_writeback_data;
        w.en    = bif.register_writeback_enable;
        w.rg    = bif.writeback_register_encoding;
        w.sel   = bif.writeback_data_select_hotcode;
        return w;
    endfunction

    // Expected writeback bundle for an accepted instruction: every field passes through, memory data supplied.
    function automatic wb_t pass_wb(input in_t v, input logic [31:0] md);
        wb_t w;
        w.instr = v.instr;
        w.mem   = md;
        w.arith = v.arith;
        w.move  = v.move;
        w.en    = v.en;
        w.rg    = v.rg;
        w.sel   = v.sel;
        return w;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.valid = ($urandom_range(0, 4) != 0);
        v.instr = $urandom;
        v.op    = 2'($urandom_range(0, 3));
        v.addr  = $urandom;
        v.sdata = $urandom;
        v.arith = $urandom;
        v.move  = $urandom;
        v.en    = 2'($urandom_range(0, 3));
        v.rg    = 3'($urandom_range(0, 7));
        v.sel   = 3'($urandom_range(0, 7));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_wb(input string name, input wb_t exp);
        wb_t a;
        a = actual_wb();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    vec_t tbl[5];
    in_t  ld, st, alu, idle_in;
    int   stall_cycles;

    initial begin
        idle_in = '0;
        drive(idle_in);
        bif.dmem_ack   = 1'b0;
        bif.dmem_rdata = '0;

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk_wb("reset_wb", BUBBLE);
        chk("reset_stall", 32'(bif.mem_stall), 32'd0);
        chk("reset_req", 32'(bif.dmem_req), 32'd0);
        chk("reset_we", 32'(bif.dmem_we), 32'd0);
        chk("reset_addr", 32'(bif.dmem_addr), 32'd0);
        chk("reset_wdata", bif.dmem_wdata, 32'd0);
        chk("reset_fault", 32'(bif.mem_fault), 32'd0);
        rst_n = 1'b1;

        // non-memory vectors, back-to-back
        tbl[0].in  = '{1'b1, 32'h0000_0A01, 2'b00, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 2'b01, 3'd3, 3'b100};
        tbl[0].exp = '{32'h0000_0A01, 32'h0, 32'h1234_5678, 32'h0, 2'b01, 3'd3, 3'b100};
        tbl[1].in  = '{1'b1, 32'h1111_2222, 2'b00, 32'h55, 32'h66, 32'h0, 32'hA5A5_5A5A, 2'b11, 3'd5, 3'b001};
        tbl[1].exp = '{32'h1111_2222, 32'h0, 32'h0, 32'hA5A5_5A5A, 2'b11, 3'd5, 3'b001};
        tbl[2].in  = '{1'b1, 32'hFFFF_0000, 2'b11, 32'h40, 32'h77, 32'h9, 32'h8, 2'b10, 3'd7, 3'b100};
        tbl[2].exp = '{32'hFFFF_0000, 32'h0, 32'h9, 32'h8, 2'b10, 3'd7, 3'b100};
        tbl[3].in  = '{1'b0, 32'h1, 2'b01, 32'h50, 32'h1, 32'h2, 32'h3, 2'b01, 3'd1, 3'b010};
        tbl[3].exp = '0;
        tbl[4].in  = '{1'b1, 32'h8000_0001, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 2'b00, 3'd0, 3'b100};
        tbl[4].exp = '{32'h8000_0001, 32'h0, 32'hFFFF_FFFF, 32'h1, 2'b00, 3'd0, 3'b100};
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].in);
            tick();
            chk_wb($sformatf("vec%0d_wb", i), tbl[i].exp);
            chk($sformatf("vec%0d_stall", i), 32'(bif.mem_stall), 32'd0);
            chk($sformatf("vec%0d_req", i), 32'(bif.dmem_req), 32'd0);
        end

        // load, 3 wait cycles then ack; upper address bits must be dropped
        ld = '{1'b1, 32'hABCD_0001, 2'b01, 32'hFFFF_0010, 32'h0, 32'h0, 32'h0, 2'b01, 3'd2, 3'b010};
        drive(ld);
        tick();
        stall_cycles = 0;
        if (bif.mem_stall) stall_cycles++;
        chk("ld_req", 32'(bif.dmem_req), 32'd1);
        chk("ld_we", 32'(bif.dmem_we), 32'd0);
        chk("ld_addr", 32'(bif.dmem_addr), 32'h0010);
        chk_wb("ld_bubble0", BUBBLE);
        st = '{1'b1, 32'h9, 2'b10, 32'h99, 32'h1, 32'h2, 32'h3, 2'b11, 3'd1, 3'b100};
        drive(st);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bif.mem_stall) stall_cycles++;
            chk($sformatf("ld_wait%0d_addr", k), 32'(bif.dmem_addr), 32'h0010);
            chk($sformatf("ld_wait%0d_we", k), 32'(bif.dmem_we), 32'd0);
            chk_wb($sformatf("ld_wait%0d_bubble", k), BUBBLE);
        end
        bif.dmem_ack   = 1'b1;
        bif.dmem_rdata = 32'hDEAD_BEEF;
        tick();
        bif.dmem_ack = 1'b0;
        drive(idle_in);
        if (bif.mem_stall) stall_cycles++;
        chk("ld_stall_cycles", 32'(stall_cycles), 32'd4);
        chk_wb("ld_result", pass_wb(ld, 32'hDEAD_BEEF));
        chk("ld_req_drop", 32'(bif.dmem_req), 32'd0);

        // store, zero-wait ack, then an ALU op held during the ack cycle
        st  = '{1'b1, 32'h5555_AAAA, 2'b10, 32'h0020, 32'hCAFE_F00D, 32'h1, 32'h2, 2'b10, 3'd6, 3'b010};
        alu = '{1'b1, 32'h0000_0B02, 2'b00, 32'h0, 32'h0, 32'h0000_0042, 32'h0, 2'b01, 3'd4, 3'b100};
        drive(st);
        tick();
        chk("st_we", 32'(bif.dmem_we), 32'd1);
        chk("st_wdata", bif.dmem_wdata, 32'hCAFE_F00D);
        chk("st_addr", 32'(bif.dmem_addr), 32'h0020);
        chk("st_stall", 32'(bif.mem_stall), 32'd1);
        bif.dmem_ack   = 1'b1;
        bif.dmem_rdata = 32'h7777_7777;
        drive(alu);
        tick();
        bif.dmem_ack = 1'b0;
        chk_wb("st_result", pass_wb(st, 32'h0));
        chk("st_stall_drop", 32'(bif.mem_stall), 32'd0);
        tick();
        drive(idle_in);
        chk_wb("alu_after_st", pass_wb(alu, 32'h0));

        // reset mid-ACCESS
        ld = '{1'b1, 32'h0000_0C03, 2'b01, 32'h0030, 32'h0, 32'h5, 32'h6, 2'b01, 3'd1, 3'b010};
        drive(ld);
        tick();
        drive(idle_in);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(bif.dmem_req), 32'd0);
        chk("rst_mid_stall", 32'(bif.mem_stall), 32'd0);
        chk("rst_mid_addr", 32'(bif.dmem_addr), 32'd0);
        chk_wb("rst_mid_wb", BUBBLE);
        tick();
        rst_n = 1'b1;
        ld = '{1'b1, 32'h0000_0D04, 2'b01, 32'h0044, 32'h0, 32'h0, 32'h0, 2'b11, 3'd7, 3'b010};
        drive(ld);
        tick();
        drive(idle_in);
        bif.dmem_ack   = 1'b1;
        bif.dmem_rdata = 32'h1357_9BDF;
        tick();
        bif.dmem_ack = 1'b0;
        chk_wb("post_rst_ld", pass_wb(ld, 32'h1357_9BDF));

`ifdef MEM_TIMEOUT_EN
        // ack on the final allowed edge completes normally
        do_reset();
        drive(ld);
        tick();
        drive(idle_in);
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk($sformatf("to_ack_wait%0d_stall", k), 32'(bif.mem_stall), 32'd1);
        end
        bif.dmem_ack   = 1'b1;
        bif.dmem_rdata = 32'h0BAD_F00D;
        tick();
        bif.dmem_ack = 1'b0;
        chk_wb("to_ack_last_result", pass_wb(ld, 32'h0BAD_F00D));
        chk("to_ack_last_fault", 32'(bif.mem_fault), 32'd0);

        // never acked: abort on the TO-th ACCESS edge
        drive(ld);
        tick();
        drive(idle_in);
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk($sformatf("to_wait%0d_stall", k), 32'(bif.mem_stall), 32'd1);
            chk($sformatf("to_wait%0d_fault", k), 32'(bif.mem_fault), 32'd0);
        end
        tick();
        chk("to_abort_fault", 32'(bif.mem_fault), 32'd1);
        chk("to_abort_stall", 32'(bif.mem_stall), 32'd0);
        chk("to_abort_req", 32'(bif.dmem_req), 32'd0);
        chk_wb("to_abort_bubble", BUBBLE);
        drive(alu);
        tick();
        drive(idle_in);
        chk_wb("to_after_alu", pass_wb(alu, 32'h0));
        chk("to_fault_sticky", 32'(bif.mem_fault), 32'd1);
`else
        // without the timeout, ACCESS waits indefinitely
        drive(ld);
        tick();
        drive(idle_in);
        for (int k = 0; k < 10; k++) tick();
        chk("noto_stall_held", 32'(bif.mem_stall), 32'd1);
        chk("noto_fault", 32'(bif.mem_fault), 32'd0);
        bif.dmem_ack   = 1'b1;
        bif.dmem_rdata = 32'h2468_ACE0;
        tick();
        bif.dmem_ack = 1'b0;
        chk_wb("noto_result", pass_wb(ld, 32'h2468_ACE0));
`endif

        // randomized transactions against the transaction-level model
        do_reset();
        for (int n = 0; n < 80; n++) begin
            in_t v;
            logic [31:0] rd;
            int w;
            v = rand_in();
            drive(v);
            tick();
            if (!v.valid) begin
                chk_wb($sformatf("rnd%0d_bubble", n), BUBBLE);
                chk($sformatf("rnd%0d_stall", n), 32'(bif.mem_stall), 32'd0);
            end else if (v.op == 2'b01 || v.op == 2'b10) begin
                chk($sformatf("rnd%0d_req", n), 32'(bif.dmem_req), 32'd1);
                chk($sformatf("rnd%0d_we", n), 32'(bif.dmem_we), 32'(v.op == 2'b10));
                chk($sformatf("rnd%0d_addr", n), 32'(bif.dmem_addr), 32'(v.addr[AW-1:0]));
                if (v.op == 2'b10) chk($sformatf("rnd%0d_wdata", n), bif.dmem_wdata, v.sdata);
                chk_wb($sformatf("rnd%0d_bubble0", n), BUBBLE);
                w = $urandom_range(0, TO - 1);
                for (int k = 0; k < w; k++) begin
                    drive(rand_in());
                    tick();
                    chk($sformatf("rnd%0d_wstall", n), 32'(bif.mem_stall), 32'd1);
                    chk_wb($sformatf("rnd%0d_wbubble", n), BUBBLE);
                end
                rd = $urandom;
                bif.dmem_ack   = 1'b1;
                bif.dmem_rdata = rd;
                drive(rand_in());
                tick();
                bif.dmem_ack = 1'b0;
                chk_wb($sformatf("rnd%0d_memres", n), pass_wb(v, (v.op == 2'b10) ? 32'h0 : rd));
                chk($sformatf("rnd%0d_stall_drop", n), 32'(bif.mem_stall), 32'd0);
            end else begin
                chk_wb($sformatf("rnd%0d_pass", n), pass_wb(v, 32'h0));
                chk($sformatf("rnd%0d_stall", n), 32'(bif.mem_stall), 32'd0);
            end
        end
        chk("rnd_fault_clear", 32'(bif.mem_fault), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
